serial_link_vc_tx_scheduler: RTL and testbench

Transmit-side scheduler for the virtual-channel NoC bridge. It shares one AXIS egress link between `NumVc` flit sources. It tracks remote-buffer credits per VC and gates each source on them. It also chooses which VC's pending return credits ride piggyback on each outgoing packet, and issues credit-only packets when no data can be sent but credits must be returned. It sits between the per-VC flit sources and the AXIS output stage of the bridge.

---
 rtl/serial_link_vc_tx_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_serial_link_vc_tx_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_vc_tx_scheduler.sv
// rtl/serial_link_vc_tx_scheduler.sv - VC egress scheduler: credit gating, round-robin data, credit piggyback
// Optional credit flush timeout enabled by SERIAL_LINK_VC_SCHED_TIMEOUT_EN.
module serial_link_vc_tx_scheduler #(
    parameter int NumVc           = 2,
    parameter int NumCredits      = 8,
    parameter int ForceSendThresh = 4,
    parameter int CredTimeout     = 16,
    parameter int CredW           = $clog2(NumCredits + 1),
    parameter int VcW             = $clog2(NumVc)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumVc-1:0]       vc_valid_i,
    output logic [NumVc-1:0]       vc_ready_o,
    input  logic                   cred_ret_valid_i,
    input  logic [VcW-1:0]         cred_ret_vc_i,
    input  logic [CredW-1:0]       cred_ret_cnt_i,
    input  logic [NumVc-1:0]       free_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_data_valid_o,
    output logic [VcW-1:0]         out_vc_o,
    output logic [VcW-1:0]         out_cred_vc_o,
    output logic [CredW-1:0]       out_cred_cnt_o,
    output logic [NumVc*CredW-1:0] tx_credit_o
);
    typedef enum logic [1:0] {StEmpty = 2'd0, StData = 2'd1, StCred = 2'd2} state_e;

    localparam logic [CredW+1:0] MaxTx   = (CredW + 2)'(NumCredits);
    localparam logic [CredW:0]   MaxPend = (CredW + 1)'(NumCredits);

    state_e           state_q, state_d;
    logic [VcW-1:0]   out_vc_q, out_vc_d;
    logic [VcW-1:0]   out_cred_vc_q, out_cred_vc_d;
    logic [CredW-1:0] out_cred_cnt_q, out_cred_cnt_d;
    logic [VcW-1:0]   rr_q, rr_d;
    logic [CredW-1:0] tx_cred_q [NumVc];
    logic [CredW-1:0] tx_cred_d [NumVc];
    logic [CredW-1:0] pend_q [NumVc];
    logic [CredW-1:0] pend_d [NumVc];
    logic [CredW-1:0] pend_eff [NumVc];
    logic [CredW-1:0] ret_cnt [NumVc];
    logic [CredW+1:0] tx_sum [NumVc];
    logic [CredW:0]   pend_sum [NumVc];
    logic [NumVc-1:0] data_here, cred_here, elig, cred_ovf;
    logic             hs, load, any_elig, to_fire;
    logic [VcW-1:0]   winner, winner_inc, sel_vc, idx;
    logic [CredW-1:0] maxpend;

    assign hs   = (state_q != StEmpty) && out_ready_i;
    assign load = (state_q == StEmpty) || hs;

    // A held data flit has already claimed one remote slot; pend_eff drops credits leaving this cycle.
    always_comb begin
        data_here = '0;
        cred_here = '0;
        elig      = '0;
        cred_ovf  = '0;
        pend_eff  = '{default: '0};
        ret_cnt   = '{default: '0};
        tx_sum    = '{default: '0};
        pend_sum  = '{default: '0};
        tx_cred_d = '{default: '0};
        pend_d    = '{default: '0};
        for (int v = 0; v < NumVc; v++) begin
            data_here[v] = (state_q == StData) && (out_vc_q == VcW'(v));
            cred_here[v] = hs && (out_cred_vc_q == VcW'(v));
            elig[v]      = vc_valid_i[v] && (tx_cred_q[v] != '0)
                           && !(data_here[v] && (tx_cred_q[v] == CredW'(1)));
            pend_eff[v]  = cred_here[v] ? (pend_q[v] - out_cred_cnt_q) : pend_q[v];
            ret_cnt[v]   = (cred_ret_valid_i && (cred_ret_vc_i == VcW'(v))) ? cred_ret_cnt_i : '0;
            tx_sum[v]    = {2'b00, tx_cred_q[v]} + {2'b00, ret_cnt[v]}
                           - (CredW + 2)'(hs && data_here[v]);
            pend_sum[v]  = {1'b0, pend_eff[v]} + (CredW + 1)'(free_i[v]);
            if (tx_sum[v] > MaxTx) begin
                tx_cred_d[v] = CredW'(NumCredits);
                cred_ovf[v]  = 1'b1;
            end else begin
                tx_cred_d[v] = tx_sum[v][CredW-1:0];
            end
            if (pend_sum[v] > MaxPend) begin
                pend_d[v] = CredW'(NumCredits);
            end else begin
                pend_d[v] = pend_sum[v][CredW-1:0];
            end
        end
    end

    always_comb begin
        any_elig = 1'b0;
        winner   = rr_q;
        idx      = '0;
        for (int i = 0; i < NumVc; i++) begin
            idx = VcW'((int'(rr_q) + i) % NumVc);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                winner   = idx;
            end
        end
        winner_inc = (winner == VcW'(NumVc - 1)) ? '0 : winner + VcW'(1);
        sel_vc  = '0;
        maxpend = pend_eff[0];
        for (int v = 1; v < NumVc; v++) begin
            if (pend_eff[v] > maxpend) begin
                maxpend = pend_eff[v];
                sel_vc  = VcW'(v);
            end
        end
    end

`ifdef SERIAL_LINK_VC_SCHED_TIMEOUT_EN
    localparam int ToW = $clog2(CredTimeout + 1);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    assign to_fire = (to_cnt_q == ToW'(CredTimeout - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if ((maxpend == '0) || (hs && (out_cred_cnt_q != '0))) begin
            to_cnt_d = '0;
        end else if (!to_fire) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StEmpty;
            out_vc_q       <= '0;
            out_cred_vc_q  <= '0;
            out_cred_cnt_q <= '0;
            rr_q           <= '0;
            for (int v = 0; v < NumVc; v++) begin
                tx_cred_q[v] <= CredW'(NumCredits);
                pend_q[v]    <= '0;
            end
        end else begin
            state_q        <= state_d;
            out_vc_q       <= out_vc_d;
            out_cred_vc_q  <= out_cred_vc_d;
            out_cred_cnt_q <= out_cred_cnt_d;
            rr_q           <= rr_d;
            for (int v = 0; v < NumVc; v++) begin
                tx_cred_q[v] <= tx_cred_d[v];
                pend_q[v]    <= pend_d[v];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        out_vc_d       = out_vc_q;
        out_cred_vc_d  = out_cred_vc_q;
        out_cred_cnt_d = out_cred_cnt_q;
        rr_d           = rr_q;
        if (load) begin
            if (any_elig) begin
                state_d        = StData;
                out_vc_d       = winner;
                out_cred_vc_d  = sel_vc;
                out_cred_cnt_d = maxpend;
                rr_d           = winner_inc;
            end else if ((maxpend >= CredW'(ForceSendThresh)) || to_fire) begin
                state_d        = StCred;
                out_cred_vc_d  = sel_vc;
                out_cred_cnt_d = maxpend;
            end else begin
                state_d = StEmpty;
            end
        end
    end

    always_comb begin
        vc_ready_o = '0;
        if (load && any_elig) begin
            vc_ready_o[winner] = 1'b1;
        end
        out_valid_o      = (state_q != StEmpty);
        out_data_valid_o = (state_q == StData);
        out_vc_o         = out_vc_q;
        out_cred_vc_o    = out_cred_vc_q;
        out_cred_cnt_o   = out_cred_cnt_q;
        tx_credit_o      = '0;
        for (int v = 0; v < NumVc; v++) begin
            tx_credit_o[v*CredW +: CredW] = tx_cred_q[v];
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) cred_ovf == '0);

endmodule

// File: tb/tb_serial_link_vc_tx_scheduler.sv
// tb/tb_serial_link_vc_tx_scheduler.sv - table vectors plus packet scoreboard for the VC tx scheduler
module tb_serial_link_vc_tx_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] vc_valid, vc_ready, free;
    logic       cr_v, cr_vc;
    logic [3:0] cr_cnt;
    logic       out_valid, out_ready, out_dv, out_vc, out_cvc;
    logic [3:0] out_cnt;
    logic [7:0] tx_credit;

    always #5 clk = ~clk;

    serial_link_vc_tx_scheduler dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .vc_valid_i      (vc_valid),
        .vc_ready_o      (vc_ready),
        .cred_ret_valid_i(cr_v),
        .cred_ret_vc_i   (cr_vc),
        .cred_ret_cnt_i  (cr_cnt),
        .free_i          (free),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_valid_o(out_dv),
        .out_vc_o        (out_vc),
        .out_cred_vc_o   (out_cvc),
        .out_cred_cnt_o  (out_cnt),
        .tx_credit_o     (tx_credit)
    );

    typedef struct packed {
        logic       dv;
        logic       vc;
        logic       cvc;
        logic [3:0] cnt;
    } pkt_t;

    typedef struct packed {
        logic [1:0] vv;
        logic       rdy;
        logic [1:0] fr;
        logic       ev;
        logic       edv;
        logic       evc;
        logic       ecvc;
        logic [3:0] ecnt;
        logic [1:0] erdy;
        logic [7:0] etx;
    } vec_t;

    vec_t tbl [10];
    pkt_t exp_q [$];
    int   n_vec, n_err, cyc, first_hs, p;
    bit   mon_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void push(input logic dv, input logic vc, input logic cvc, input logic [3:0] cnt);
        pkt_t e;
        e = '{dv, dv ? vc : 1'b0, cvc, cnt};
        exp_q.push_back(e);
    endfunction

    task automatic step();
        pkt_t act, e;
        @(negedge clk);
        if (mon_en && out_valid && out_ready) begin
            act = '{out_dv, out_dv ? out_vc : 1'b0, out_cvc, out_cnt};
            if (first_hs < 0) first_hs = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pkt_unexpected: got %0h expected none", act);
            end else begin
                e = exp_q.pop_front();
                chk("pkt", 32'(act), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic end_check(input string nm);
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vc_valid = '0; free = '0; cr_v = 1'b0; cr_vc = 1'b0; cr_cnt = '0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; first_hs = -1; mon_en = 1'b0;
        //           vv     rdy   fr     ev    edv   evc   ecvc  ecnt  erdy   etx
        tbl[0] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 8'h88};
        tbl[1] = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b01, 8'h88};
        tbl[2] = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b10, 8'h88};
        tbl[3] = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 2'b01, 8'h87};
        tbl[4] = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 8'h77};
        tbl[5] = '{2'b11, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 8'h77};
        tbl[6] = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 8'h77};
        tbl[7] = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b10, 8'h77};
        tbl[8] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 2'b00, 8'h76};
        tbl[9] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 8'h66};

        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_dv", out_dv, 0);
        chk("rst_vc", out_vc, 0);
        chk("rst_cvc", out_cvc, 0);
        chk("rst_cnt", out_cnt, 0);
        chk("rst_ready", vc_ready, 0);
        chk("rst_tx", tx_credit, 8'h88);

        // round-robin order and a three-cycle stall
        for (int i = 0; i < 10; i++) begin
            vc_valid = tbl[i].vv; out_ready = tbl[i].rdy; free = tbl[i].fr;
            @(negedge clk);
            chk($sformatf("t%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("t%0d_ready", i), vc_ready, tbl[i].erdy);
            chk($sformatf("t%0d_tx", i), tx_credit, tbl[i].etx);
            if (tbl[i].ev) begin
                chk($sformatf("t%0d_dv", i), out_dv, tbl[i].edv);
                chk($sformatf("t%0d_vc", i), out_vc, tbl[i].evc);
                chk($sformatf("t%0d_cvc", i), out_cvc, tbl[i].ecvc);
                chk($sformatf("t%0d_cnt", i), out_cnt, tbl[i].ecnt);
            end
            @(posedge clk);
            #1;
        end
        free = '0; vc_valid = '0;

        // reset credits: exactly eight VC0 flits
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) push(1'b1, 1'b0, 1'b0, 4'd0);
        vc_valid = 2'b01; out_ready = 1'b1;
        repeat (14) step();
        chk("rc_valid_after", out_valid, 0);
        chk("rc_tx0", tx_credit[3:0], 0);
        end_check("rc_queue");

        // exhaust VC1, then return 3 credits
        for (int i = 0; i < 8; i++) push(1'b1, 1'b1, 1'b0, 4'd0);
        vc_valid = 2'b10;
        repeat (12) step();
        chk("ret_tx1_empty", tx_credit[7:4], 0);
        end_check("ret_exhaust_queue");
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b0, 4'd0);
        cr_v = 1'b1; cr_vc = 1'b1; cr_cnt = 4'd3;
        step();
        cr_v = 1'b0;
        repeat (8) step();
        chk("ret_tx1_after3", tx_credit[7:4], 0);
        end_check("ret_three_queue");

        // return and data handshake in one cycle: net +2
        vc_valid = 2'b00; cr_v = 1'b1; cr_cnt = 4'd1;
        step();
        cr_v = 1'b0;
        chk("net_tx1_pre", tx_credit[7:4], 1);
        push(1'b1, 1'b1, 1'b0, 4'd0);
        vc_valid = 2'b10;
        step();
        vc_valid = 2'b00; cr_v = 1'b1; cr_cnt = 4'd3;
        step();
        cr_v = 1'b0;
        step();
        chk("net_tx1_plus2", tx_credit[7:4], 3);
        end_check("net_queue");

        // reset while a packet is held discards it
        out_ready = 1'b0; vc_valid = 2'b10;
        step();
        step();
        chk("held_valid", out_valid, 1);
        rst_n = 1'b0; vc_valid = 2'b00;
        step();
        rst_n = 1'b1;
        chk("rst_discard_valid", out_valid, 0);
        chk("rst_discard_tx", tx_credit, 8'h88);

        // forced credit-only packet after four frees on VC0
        out_ready = 1'b1;
        push(1'b0, 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 4; i++) begin
            free = 2'b01;
            step();
        end
        free = 2'b00;
        repeat (6) step();
        push(1'b1, 1'b1, 1'b0, 4'd0);
        vc_valid = 2'b10;
        step();
        vc_valid = 2'b00;
        repeat (3) step();
        end_check("force_queue");

        // single free on VC1 then idle
        do_reset();
        out_ready = 1'b1;
`ifdef SERIAL_LINK_VC_SCHED_TIMEOUT_EN
        push(1'b0, 1'b0, 1'b1, 4'd1);
`endif
        free = 2'b10;
        p = cyc;
        first_hs = -1;
        step();
        free = 2'b00;
        repeat (30) step();
`ifdef SERIAL_LINK_VC_SCHED_TIMEOUT_EN
        chk("to_latency", 32'(first_hs - p), 17);
`else
        chk("to_none", 32'(first_hs), 32'hffff_ffff);
`endif
        end_check("to_queue");

        // piggyback selection and snapshot stability
        do_reset();
        push(1'b1, 1'b0, 1'b0, 4'd0);
        push(1'b1, 1'b0, 1'b1, 4'd5);
        push(1'b1, 1'b1, 1'b0, 4'd2);
        push(1'b1, 1'b1, 1'b1, 4'd1);
        vc_valid = 2'b01; out_ready = 1'b0;
        step();
        free = 2'b11;
        repeat (2) step();
        free = 2'b10;
        repeat (3) step();
        free = 2'b00; out_ready = 1'b1;
        step();
        vc_valid = 2'b00; out_ready = 1'b0; free = 2'b10;
        step();
        chk("snap_cnt_held", out_cnt, 5);
        free = 2'b00; out_ready = 1'b1;
        step();
        vc_valid = 2'b10;
        repeat (2) step();
        vc_valid = 2'b00;
        repeat (4) step();
        end_check("snap_queue");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
